// File: rtl/fu_issue_sequencer.sv
// Issue-side sequencer: handshake in, drive function unit, capture, handshake out.
// Optional overflow trap enabled by defining FU_OVERFLOW_TRAP_EN.
module fu_issue_sequencer #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        OpValid,
   output logic        OpReady,
   input  logic [7:0]  OpCtl,
   input  logic [3:0]  OpCond,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic [4:0]  OpSh,
   input  logic [4:0]  OpDest,
   output logic [4:0]  FS,
   output logic [4:0]  SH,
   output logic [31:0] ABus,
   output logic [31:0] BBus,
   input  logic [31:0] F,
   input  logic        V,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   output logic        ResValid,
   input  logic        ResReady,
   output logic [31:0] Result,
   output logic [4:0]  ResDest,
   output logic [3:0]  Status,
   output logic        ErrIllegal,
   output logic        Skipped,
   output logic        Trap
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic [1:0] cnt;
   logic       set_flags;
   logic       no_write;
   logic       accept;
   logic       cond_ok;
   logic       illegal;
   logic       trap_hit;
   logic [4:0] fs_acc;

   assign OpReady  = (state == IDLE);
   assign ResValid = (state == RESP);
   assign accept   = OpValid && OpReady;

   always_comb begin
      cond_ok = 1'b0;
      case (OpCond)
         4'd0:    cond_ok = 1'b1;
         4'd1:    cond_ok = Status[0];
         4'd2:    cond_ok = !Status[0];
         4'd3:    cond_ok = Status[2];
         4'd4:    cond_ok = !Status[2];
         4'd5:    cond_ok = Status[1];
         4'd6:    cond_ok = !Status[1];
         4'd7:    cond_ok = Status[3];
         4'd8:    cond_ok = !Status[3];
         default: cond_ok = 1'b0;
      endcase
   end

   // codes 9..14 are reserved; 15 is a legal "never"
   assign illegal = ((OpCond >= 4'd9) && (OpCond <= 4'd14))
                 || (OpCtl[7] && (OpCtl[4:3] != 2'b00))
                 || (OpCtl[5] && !OpCtl[6]);

   assign fs_acc = OpCtl[7] ? {OpCtl[4:1], Status[2]} : OpCtl[4:0];

`ifdef FU_OVERFLOW_TRAP_EN
   assign trap_hit = (FS[4:3] == 2'b00) && set_flags && V;
`else
   assign trap_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         set_flags  <= 1'b0;
         no_write   <= 1'b0;
         FS         <= 5'd0;
         SH         <= 5'd0;
         ABus       <= 32'd0;
         BBus       <= 32'd0;
         Result     <= 32'd0;
         ResDest    <= 5'd0;
         Status     <= 4'd0;
         ErrIllegal <= 1'b0;
         Skipped    <= 1'b0;
      end else begin
         ErrIllegal <= 1'b0;
         Skipped    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     ErrIllegal <= 1'b1;
                  end else if (!cond_ok) begin
                     Skipped <= 1'b1;
                  end else begin
                     FS        <= fs_acc;
                     SH        <= OpSh;
                     ABus      <= OpA;
                     BBus      <= OpB;
                     ResDest   <= OpDest;
                     set_flags <= OpCtl[6];
                     no_write  <= OpCtl[5];
                     cnt       <= 2'(EXEC_CYCLES - 1);
                     state     <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt == 2'd0) begin
                  Result <= F;
                  if (set_flags) Status <= {V, C, N, Z};
                  if (no_write || trap_hit) state <= IDLE;
                  else                      state <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (ResReady) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FU_OVERFLOW_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) Trap <= 1'b0;
      else        Trap <= (state == EXEC) && (cnt == 2'd0) && trap_hit;
   end
`else
   assign Trap = 1'b0;
`endif

endmodule
